// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised UART receiver driven by an external oversample tick.
// Supports DATA_BITS data bits (5..9, LSB first), runtime parity
// (none/even/odd) and one or two stop bits. Received words are presented in a
// holding register with a valid/ready handshake.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   - each bit is the majority of three samples taken at the last
//               three counts of the bit
//   undefined - each bit is the single sample at the last count of the bit
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   tick         oversample strobe (OVERSAMPLE per bit time)
//   en           receive enable, gates start detection only
//   rx           asynchronous serial line, idle high
//   parity_mode  00/11 none, 01 even, 10 odd (latched at start of frame)
//   two_stop     1 = two stop bits (latched at start of frame)
//   data_out     received word
//   valid        data_out holds an unconsumed word
//   ready        consumer accepts when valid & ready
//   frame_err    a stop bit of data_out's frame was sampled low
//   parity_err   parity mismatch on data_out's frame
//   overrun      sticky: a frame was dropped because the holding register was full
//   busy         frame in progress
module uart_rx_ext #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;

    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

    logic                 rx_s1, rx_s2;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        last_cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           pm_l;
    logic                 ts_l;
    logic                 ferr, perr;
    logic                 sample;
    logic                 at_last;
    logic                 complete;
    logic                 par_en;
    logic                 par_x;

    // START is only half a bit long so its sample lands mid start bit.
    always_comb begin
        last_cnt = (state == START) ? HALF_LAST : BIT_LAST;
        at_last  = tick && (cnt == last_cnt);
        complete = at_last && (((state == STOP1) && !ts_l) || (state == STOP2));
        par_en   = (pm_l == 2'b01) || (pm_l == 2'b10);
        par_x    = (^shreg) ^ sample;
    end

`ifdef UART_RX_MAJORITY_EN
    logic v1, v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (tick) begin
            if (cnt == last_cnt - CW'(2)) v1 <= rx_s2;
            if (cnt == last_cnt - CW'(1)) v2 <= rx_s2;
        end
    end

    always_comb sample = (v1 & v2) | (v1 & rx_s2) | (v2 & rx_s2);
`else
    always_comb sample = rx_s2;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            pm_l       <= '0;
            ts_l       <= 1'b0;
            ferr       <= 1'b0;
            perr       <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;

            // A completing frame takes priority over a plain handshake; when
            // both coincide the new word replaces the consumed one.
            if (complete) begin
                if (!valid || ready) begin
                    data_out   <= shreg;
                    frame_err  <= ferr | ~sample;
                    parity_err <= perr;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (state == IDLE) begin
                cnt <= '0;
                idx <= '0;
                if (tick && en && !rx_s2) begin
                    state <= START;
                    pm_l  <= parity_mode;
                    ts_l  <= two_stop;
                    ferr  <= 1'b0;
                    perr  <= 1'b0;
                end
            end else if (tick) begin
                if (cnt != last_cnt) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    cnt <= '0;
                    case (state)
                        START: state <= sample ? IDLE : DATA;
                        DATA: begin
                            // LSB arrives first, so shift in from the top.
                            shreg <= {sample, shreg[DATA_BITS-1:1]};
                            if (idx == IW'(DATA_BITS - 1)) begin
                                idx   <= '0;
                                state <= par_en ? PARITY : STOP1;
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end
                        PARITY: begin
                            perr  <= (pm_l == 2'b01) ? par_x : ~par_x;
                            state <= STOP1;
                        end
                        STOP1: begin
                            if (!sample) ferr <= 1'b1;
                            state <= ts_l ? STOP2 : IDLE;
                        end
                        STOP2:   state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
module tb_uart_rx_ext;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       en = 1'b1;
    logic       rx = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] data_out;
    logic       valid, frame_err, parity_err, overrun, busy;

    int total = 0;
    int bad = 0;
    logic pre_valid;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;
    exp_t sb[$];

    uart_rx_ext #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .rx(rx),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .data_out(data_out), .valid(valid), .ready(ready),
        .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line value is set three clocks ahead so it has passed the synchroniser
    // by the time the tick is seen.
    task automatic one_tick(input logic v);
        rx = v;
        repeat (3) @(negedge clk);
        pre_valid = valid;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic line_ticks(input logic v, input int n);
        for (int i = 0; i < n; i++) one_tick(v);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic s1, input logic s2, input logic two,
                              input int gbit, input int gcnt);
        line_ticks(1'b0, 1 + OS / 2);
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < OS; c++)
                one_tick((b == gbit && c == gcnt) ? ~d[b] : d[b]);
        if (has_par) line_ticks(pbit, OS);
        line_ticks(s1, OS);
        if (two) line_ticks(s2, OS);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        return e;
    endfunction

    // Monitor: compare each consumed word against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else begin
                    e = sb.pop_front();
                    check("word_data", {24'd0, data_out}, {24'd0, e.d});
                    check("word_frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                    check("word_parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, data_out, valid, frame_err, parity_err, overrun, busy}, 32'd0);
        rst = 1'b0;
        line_ticks(1'b1, 3);

        // 8N1 0xA5 with latency check on the final stop tick
        sb.push_back(mk(8'hA5, 1'b0, 1'b0));
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        check("latency_pre", {31'd0, pre_valid}, 32'd0);
        check("latency_post", {31'd0, valid}, 32'd1);
        check("overrun_clear", {31'd0, overrun}, 32'd0);
        line_ticks(1'b1, 2);

        // even parity
        parity_mode = 2'b01;
        sb.push_back(mk(8'h03, 1'b0, 1'b1));
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0);
        line_ticks(1'b1, 2);
        sb.push_back(mk(8'h03, 1'b0, 1'b0));
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        line_ticks(1'b1, 2);
        // odd parity: 0x07 has odd ones, pbit 0 -> ok
        parity_mode = 2'b10;
        sb.push_back(mk(8'h07, 1'b0, 1'b0));
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        line_ticks(1'b1, 2);
        parity_mode = 2'b00;

        // two stop bits
        two_stop = 1'b1;
        sb.push_back(mk(8'h5A, 1'b1, 1'b0));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0);
        line_ticks(1'b1, 2);
        sb.push_back(mk(8'h5A, 1'b0, 1'b0));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0);
        line_ticks(1'b1, 2);
        two_stop = 1'b0;

        // overrun: second word dropped
        ready = 1'b0;
        sb.push_back(mk(8'h11, 1'b0, 1'b0));
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        line_ticks(1'b1, 2);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
        line_ticks(1'b1, 2);
        check("ovr_data_held", {24'd0, data_out}, 32'h11);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #2;
        check("ovr_valid_cleared", {31'd0, valid}, 32'd0);
        check("ovr_flag_cleared", {31'd0, overrun}, 32'd0);
        ready = 1'b1;

        // false start
        one_tick(1'b0);
        check("fs_busy_start", {31'd0, busy}, 32'd1);
        line_ticks(1'b0, 4);
        line_ticks(1'b1, 3);
        check("fs_busy_before_sample", {31'd0, busy}, 32'd1);
        one_tick(1'b1);
        check("fs_busy_after", {31'd0, busy}, 32'd0);
        check("fs_no_valid", {31'd0, valid}, 32'd0);

        // en=0 ignores a low line
        en = 1'b0;
        line_ticks(1'b0, 20);
        check("en_off_busy", {31'd0, busy}, 32'd0);
        line_ticks(1'b1, 2);
        en = 1'b1;

        // glitches on bit 0 of 0x00: count 14 never matters, count 15 only
        // matters for the single-sample build
        sb.push_back(mk(8'h00, 1'b0, 1'b0));
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 14);
        line_ticks(1'b1, 2);
`ifdef UART_RX_MAJORITY_EN
        sb.push_back(mk(8'h00, 1'b0, 1'b0));
`else
        sb.push_back(mk(8'h01, 1'b0, 1'b0));
`endif
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 15);
        line_ticks(1'b1, 2);

        // break: two full frame lengths low -> two 0x00 words with frame_err
        sb.push_back(mk(8'h00, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 1'b1, 1'b0));
        line_ticks(1'b0, 2 * (1 + OS / 2 + 9 * OS));
        line_ticks(1'b1, 3);

        // reset at data bit 4 of a frame
        line_ticks(1'b0, 1 + OS / 2);
        line_ticks(1'b1, 4 * OS);
        check("mid_frame_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_outputs", {20'd0, data_out, valid, frame_err, parity_err, overrun, busy}, 32'd0);
        line_ticks(1'b1, 4 * OS + 20);
        check("rst_no_word", {31'd0, valid}, 32'd0);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised UART receiver and the successor of the team's fixed 8N1 receiver. It adds a configurable data width, runtime parity (none/even/odd) and 1 or 2 stop bits. Bit timing advances on an external oversample tick rather than on every clock. The output is a holding register with a valid/ready handshake plus frame, parity and overrun flags. It sits between the pad synchroniser domain and the command/stream logic that consumes received bytes.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
OVERSAMPLE, 16, ticks per bit; even, >= 8.

Ports:
clk  in  1  clock
rst  in  1  reset
tick  in  1  oversample strobe, one clk wide, OVERSAMPLE per bit time
en  in  1  receive enable; gates start detection only
rx  in  1  asynchronous serial line, idle high
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
two_stop  in  1  1 = check two stop bits
data_out  out  DATA_BITS  received word, LSB first on line
valid  out  1  data_out holds an unconsumed word
ready  in  1  consumer accepts when valid&ready
frame_err  out  1  qualifies data_out: a stop bit sampled low
parity_err  out  1  qualifies data_out: parity mismatch
overrun  out  1  sticky: a frame was dropped because the holding register was full
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs reset to 0, state to IDLE, counters to 0. Both synchroniser flops reset to 1. rst mid-frame aborts the frame immediately and delivers no word.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Counters advance only in cycles where tick=1. The state machine may only change state on a tick cycle.
- Sample value of a bit: majority of the synchronised rx at counts OVERSAMPLE-3, -2 and -1 of that bit when the optional feature is enabled. Otherwise it is the single sample at count OVERSAMPLE-1.
- IDLE: clears the sample counter and bit index. If en=1 and rx=0 on a tick, go to START and latch parity_mode and two_stop. Changes to these inputs mid-frame are ignored.
- START: count OVERSAMPLE/2 ticks; votes are taken at counts OVERSAMPLE/2-3..-1 under the same rule. If the sample is 0, go to DATA. If it is 1, it was a false start: go to IDLE with no flags touched.
- DATA: after each OVERSAMPLE ticks, shift the sample into bit[index]. After DATA_BITS bits, go to PARITY if parity is enabled, else to STOP1.
- PARITY: sample one bit. Even mode: error if XOR(data, pbit) is 1. Odd mode: error if it is 0.
- STOP1: sample. A 0 sets the frame-error candidate. If two_stop was latched, go to STOP2, else complete.
- STOP2: sample. A 0 sets the frame-error candidate. Then complete.
- Complete (on the tick of the final stop sample) goes to IDLE. On the next clk edge:
  - If valid=0, or valid&ready in the same cycle: load data_out, frame_err and parity_err; valid<=1.
  - Otherwise: data_out and its flags are unchanged, overrun<=1, and the new word is discarded.
- Handshake: valid&ready with no completing frame in that cycle gives valid<=0 and overrun<=0. frame_err and parity_err hold until the next load.
- A word with frame_err or parity_err is still delivered; the consumer discards it.
- A line held low (break) yields repeated 0-data words with frame_err=1 while en=1.
- en=0 mid-frame: the current frame completes normally; no new start is accepted.
- Latency: valid rises 1 clk after the tick on which the last stop sample is taken.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: 3-sample majority vote for start, data, parity and stop bits. A single-tick glitch does not corrupt a bit.
- Undefined: single sample at the final count of each bit. Voting logic is removed. All other timing is identical.

Test Plan:
- DATA_BITS=8, OVERSAMPLE=16, parity none, 1 stop; send 0xA5 -> data_out=0xA5, valid=1, frame_err=0, parity_err=0, overrun=0; valid 1 clk after the stop-sample tick.
- parity_mode=01; send 0x03 with parity bit 1 -> parity_err=1, data_out=0x03. Resend with parity bit 0 -> parity_err=0.
- two_stop=1; send 0x5A with second stop bit 0 -> frame_err=1, data_out=0x5A. Resend with both stops 1 -> frame_err=0.
- ready=0; send 0x11 then 0x22 -> data_out stays 0x11, overrun=1. Pulse ready -> valid=0, overrun=0.
- rx low for 5 ticks then high -> false start: returns to IDLE, valid stays 0, busy pulses only during START.
- With UART_RX_MAJORITY_EN defined, a 1-tick high glitch at count 14 of data bit 0 of 0x00 -> data_out=0x00. Undefined, a 1-tick glitch at count 15 -> data_out=0x01. Assert rst at bit 4 of a frame -> no word delivered, all outputs 0.
